// File: rtl/axil_adapter_rd_ot.sv
// axil_adapter_rd_ot: AXI4-lite read-channel width adapter with multiple
// outstanding reads. Handles equal width, upsizing (lane extraction from a
// wide master word) and downsizing (split into narrow master beats, then
// reassemble). A small FIFO keeps per-transaction lane information in AR order.
module axil_adapter_rd_ot #(
   parameter int ADDR_WIDTH      = 32,
   parameter int S_DATA_WIDTH    = 32,
   parameter int M_DATA_WIDTH    = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
   input  logic [2:0]              s_axil_arprot,
   input  logic                    s_axil_arvalid,
   output logic                    s_axil_arready,
   output logic [S_DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]              s_axil_rresp,
   output logic                    s_axil_rvalid,
   input  logic                    s_axil_rready,
   output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
   output logic [2:0]              m_axil_arprot,
   output logic                    m_axil_arvalid,
   input  logic                    m_axil_arready,
   input  logic [M_DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]              m_axil_rresp,
   input  logic                    m_axil_rvalid,
   output logic                    m_axil_rready
);

   localparam int SB     = S_DATA_WIDTH / 8;
   localparam int MB     = M_DATA_WIDTH / 8;
   localparam bit UP     = MB > SB;
   localparam bit DN     = SB > MB;
   localparam int RATIO  = DN ? SB / MB : 1;
   localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int LANES  = UP ? MB / SB : 1;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [ADDR_WIDTH-1:0] S_MASK = ~ADDR_WIDTH'(SB - 1);

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} ar_state_t;

   ar_state_t               state_q, state_d;
   logic                    ar_last;
   logic [CNT_W-1:0]        cnt;
   logic                    rdy_en;
   logic [BEAT_W-1:0]       ar_beat;
   logic [BEAT_W-1:0]       r_beat;
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;
   logic [ADDR_WIDTH-1:0]   ar_addr;
   logic [S_DATA_WIDTH-1:0] r_data;
   logic [1:0]              r_resp;
   logic                    r_last;
   logic                    s_ar_hs, s_r_hs, m_ar_hs, m_r_hs, r_done;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // rdy_en keeps s_arready low until the first clock after reset release
   assign s_axil_arready = rdy_en && (cnt < CNT_W'(MAX_OUTSTANDING)) &&
                           (!m_axil_arvalid || m_axil_arready) && (state_q == IDLE);
   assign s_ar_hs = s_axil_arvalid && s_axil_arready;
   assign s_r_hs  = s_axil_rvalid && s_axil_rready;
   assign m_ar_hs = m_axil_arvalid && m_axil_arready;
   assign m_r_hs  = m_axil_rvalid && m_axil_rready;
   assign r_done  = m_r_hs && r_last;

   // Resized slaves address whole slave words; equal width passes through
   generate
      if (UP || DN) begin : g_mask
         assign ar_addr = s_axil_araddr & S_MASK;
      end else begin : g_nomask
         assign ar_addr = s_axil_araddr;
      end
   endgenerate

   // AR state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // AR next state: only the downsizer leaves IDLE, to walk its R beats
   always_comb begin
      state_d = state_q;
      ar_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (DN && s_ar_hs) state_d = ISSUE;
         end
         ISSUE: begin
            ar_last = (ar_beat == BEAT_W'(RATIO - 1));
            if (m_ar_hs && ar_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Ready gate released one cycle after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_en <= 1'b0;
      else        rdy_en <= 1'b1;
   end

   // Master AR register: load on slave accept, step through beats when downsizing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axil_arvalid <= 1'b0;
         m_axil_araddr  <= '0;
         m_axil_arprot  <= '0;
         ar_beat        <= '0;
      end else if (s_ar_hs) begin
         m_axil_arvalid <= 1'b1;
         m_axil_araddr  <= ar_addr;
         m_axil_arprot  <= s_axil_arprot;
         ar_beat        <= '0;
      end else if (m_ar_hs) begin
         if (state_q == ISSUE && !ar_last) begin
            m_axil_araddr <= m_axil_araddr + ADDR_WIDTH'(MB);
            ar_beat       <= ar_beat + BEAT_W'(1);
         end else begin
            m_axil_arvalid <= 1'b0;
         end
      end
   end

   // In-flight count from slave accept to slave response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cnt <= '0;
      else if (s_ar_hs && !s_r_hs) cnt <= cnt + CNT_W'(1);
      else if (!s_ar_hs && s_r_hs) cnt <= cnt - CNT_W'(1);
   end

   // Tracking FIFO pointers: push on slave accept, pop on final master beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (s_ar_hs) wr_ptr <= ptr_inc(wr_ptr);
         if (r_done)  rd_ptr <= ptr_inc(rd_ptr);
      end
   end

   // Master beat counter within a transaction (only advances when downsizing)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_beat <= '0;
      else if (m_r_hs) r_beat <= r_last ? '0 : r_beat + BEAT_W'(1);
   end

   generate
      if (DN) begin : g_dn
         logic [S_DATA_WIDTH-1:0] asm_data;
         logic [1:0]              asm_resp;

         assign r_last = (r_beat == BEAT_W'(RATIO - 1));
         // Intermediate beats land in the assembly register, never blocked
         assign m_axil_rready = !r_last || !s_axil_rvalid || s_axil_rready;

         // Capture intermediate beats and remember the first error response
         always_ff @(posedge clk) begin
            if (m_r_hs && !r_last) begin
               for (int i = 0; i < RATIO - 1; i++)
                  if (r_beat == BEAT_W'(i)) asm_data[i*M_DATA_WIDTH +: M_DATA_WIDTH] <= m_axil_rdata;
               if (r_beat == '0 || asm_resp == 2'b00) asm_resp <= m_axil_rresp;
            end
         end

         // Final beat completes the word on its way into the output register
         always_comb begin
            r_data = asm_data;
            r_data[(RATIO-1)*M_DATA_WIDTH +: M_DATA_WIDTH] = m_axil_rdata;
            r_resp = (asm_resp != 2'b00) ? asm_resp : m_axil_rresp;
         end
      end else if (UP) begin : g_up
         logic [LANE_W-1:0] lane_mem [MAX_OUTSTANDING];
         logic [LANE_W-1:0] lane_in, lane_head;

         assign lane_in       = s_axil_araddr[$clog2(MB)-1:$clog2(SB)];
         assign lane_head     = lane_mem[rd_ptr];
         assign r_last        = 1'b1;
         assign m_axil_rready = !s_axil_rvalid || s_axil_rready;

         // Lane index storage, in AR order
         always_ff @(posedge clk) begin
            if (s_ar_hs) lane_mem[wr_ptr] <= lane_in;
         end

         // Pick the slave lane out of the wide master word
         always_comb begin
            r_data = m_axil_rdata[S_DATA_WIDTH-1:0];
            for (int i = 1; i < LANES; i++)
               if (lane_head == LANE_W'(i)) r_data = m_axil_rdata[i*S_DATA_WIDTH +: S_DATA_WIDTH];
            r_resp = m_axil_rresp;
         end
      end else begin : g_eq
         assign r_last        = 1'b1;
         assign m_axil_rready = !s_axil_rvalid || s_axil_rready;
         assign r_data        = m_axil_rdata;
         assign r_resp        = m_axil_rresp;
      end
   endgenerate

   // Slave R output register: holds until the slave takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_axil_rvalid <= 1'b0;
         s_axil_rdata  <= '0;
         s_axil_rresp  <= '0;
      end else if (r_done) begin
         s_axil_rvalid <= 1'b1;
         s_axil_rdata  <= r_data;
         s_axil_rresp  <= r_resp;
      end else if (s_r_hs) begin
         s_axil_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axil_adapter_rd_ot.sv
// Directed bench for axil_adapter_rd_ot: three instances cover equal (32/32),
// upsize (S32/M64) and downsize (S64/M32) configurations.
module tb_axil_adapter_rd_ot;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int acc;

   // equal-width instance signals
   logic [31:0] e_s_araddr;  logic [2:0] e_s_arprot;  logic e_s_arvalid, e_s_arready;
   logic [31:0] e_s_rdata;   logic [1:0] e_s_rresp;   logic e_s_rvalid, e_s_rready;
   logic [31:0] e_m_araddr;  logic [2:0] e_m_arprot;  logic e_m_arvalid, e_m_arready;
   logic [31:0] e_m_rdata;   logic [1:0] e_m_rresp;   logic e_m_rvalid, e_m_rready;
   // upsize instance signals
   logic [31:0] u_s_araddr;  logic [2:0] u_s_arprot;  logic u_s_arvalid, u_s_arready;
   logic [31:0] u_s_rdata;   logic [1:0] u_s_rresp;   logic u_s_rvalid, u_s_rready;
   logic [31:0] u_m_araddr;  logic [2:0] u_m_arprot;  logic u_m_arvalid, u_m_arready;
   logic [63:0] u_m_rdata;   logic [1:0] u_m_rresp;   logic u_m_rvalid, u_m_rready;
   // downsize instance signals
   logic [31:0] d_s_araddr;  logic [2:0] d_s_arprot;  logic d_s_arvalid, d_s_arready;
   logic [63:0] d_s_rdata;   logic [1:0] d_s_rresp;   logic d_s_rvalid, d_s_rready;
   logic [31:0] d_m_araddr;  logic [2:0] d_m_arprot;  logic d_m_arvalid, d_m_arready;
   logic [31:0] d_m_rdata;   logic [1:0] d_m_rresp;   logic d_m_rvalid, d_m_rready;

   axil_adapter_rd_ot #(.ADDR_WIDTH(32), .S_DATA_WIDTH(32), .M_DATA_WIDTH(32), .MAX_OUTSTANDING(4)) u_eq (
      .clk(clk), .rst_n(rst_n),
      .s_axil_araddr(e_s_araddr), .s_axil_arprot(e_s_arprot), .s_axil_arvalid(e_s_arvalid), .s_axil_arready(e_s_arready),
      .s_axil_rdata(e_s_rdata), .s_axil_rresp(e_s_rresp), .s_axil_rvalid(e_s_rvalid), .s_axil_rready(e_s_rready),
      .m_axil_araddr(e_m_araddr), .m_axil_arprot(e_m_arprot), .m_axil_arvalid(e_m_arvalid), .m_axil_arready(e_m_arready),
      .m_axil_rdata(e_m_rdata), .m_axil_rresp(e_m_rresp), .m_axil_rvalid(e_m_rvalid), .m_axil_rready(e_m_rready));

   axil_adapter_rd_ot #(.ADDR_WIDTH(32), .S_DATA_WIDTH(32), .M_DATA_WIDTH(64), .MAX_OUTSTANDING(4)) u_up (
      .clk(clk), .rst_n(rst_n),
      .s_axil_araddr(u_s_araddr), .s_axil_arprot(u_s_arprot), .s_axil_arvalid(u_s_arvalid), .s_axil_arready(u_s_arready),
      .s_axil_rdata(u_s_rdata), .s_axil_rresp(u_s_rresp), .s_axil_rvalid(u_s_rvalid), .s_axil_rready(u_s_rready),
      .m_axil_araddr(u_m_araddr), .m_axil_arprot(u_m_arprot), .m_axil_arvalid(u_m_arvalid), .m_axil_arready(u_m_arready),
      .m_axil_rdata(u_m_rdata), .m_axil_rresp(u_m_rresp), .m_axil_rvalid(u_m_rvalid), .m_axil_rready(u_m_rready));

   axil_adapter_rd_ot #(.ADDR_WIDTH(32), .S_DATA_WIDTH(64), .M_DATA_WIDTH(32), .MAX_OUTSTANDING(4)) u_dn (
      .clk(clk), .rst_n(rst_n),
      .s_axil_araddr(d_s_araddr), .s_axil_arprot(d_s_arprot), .s_axil_arvalid(d_s_arvalid), .s_axil_arready(d_s_arready),
      .s_axil_rdata(d_s_rdata), .s_axil_rresp(d_s_rresp), .s_axil_rvalid(d_s_rvalid), .s_axil_rready(d_s_rready),
      .m_axil_araddr(d_m_araddr), .m_axil_arprot(d_m_arprot), .m_axil_arvalid(d_m_arvalid), .m_axil_arready(d_m_arready),
      .m_axil_rdata(d_m_rdata), .m_axil_rresp(d_m_rresp), .m_axil_rvalid(d_m_rvalid), .m_axil_rready(d_m_rready));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      e_s_araddr = '0; e_s_arprot = '0; e_s_arvalid = 0; e_s_rready = 0;
      e_m_arready = 0; e_m_rdata = '0; e_m_rresp = '0; e_m_rvalid = 0;
      u_s_araddr = '0; u_s_arprot = '0; u_s_arvalid = 0; u_s_rready = 0;
      u_m_arready = 0; u_m_rdata = '0; u_m_rresp = '0; u_m_rvalid = 0;
      d_s_araddr = '0; d_s_arprot = '0; d_s_arvalid = 0; d_s_rready = 0;
      d_m_arready = 0; d_m_rdata = '0; d_m_rresp = '0; d_m_rvalid = 0;
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_eq_s_rvalid", 64'(e_s_rvalid), 64'd0);
      check("rst_eq_m_arvalid", 64'(e_m_arvalid), 64'd0);
      check("rst_dn_s_rdata", 64'(d_s_rdata), 64'd0);
      check("rst_up_m_araddr", 64'(u_m_araddr), 64'd0);
      rst_n = 1'b1;
      tick();
      check("rdy_eq", 64'(e_s_arready), 64'd1);
      check("rdy_up", 64'(u_s_arready), 64'd1);
      check("rdy_dn", 64'(d_s_arready), 64'd1);

      // equal width read 0x10 -> 0xDEADBEEF, then backpressure
      e_s_araddr = 32'h10; e_s_arprot = 3'b010; e_s_arvalid = 1;
      tick();
      e_s_arvalid = 0;
      check("eq_m_arvalid", 64'(e_m_arvalid), 64'd1);
      check("eq_m_araddr", 64'(e_m_araddr), 64'h10);
      check("eq_m_arprot", 64'(e_m_arprot), 64'd2);
      e_m_arready = 1;
      tick();
      e_m_arready = 0;
      check("eq_m_arvalid_drop", 64'(e_m_arvalid), 64'd0);
      e_m_rdata = 32'hDEADBEEF; e_m_rresp = 2'b00; e_m_rvalid = 1;
      #1;
      check("eq_m_rready", 64'(e_m_rready), 64'd1);
      tick();
      e_m_rvalid = 0;
      check("eq_s_rvalid", 64'(e_s_rvalid), 64'd1);
      check("eq_s_rdata", 64'(e_s_rdata), 64'hDEADBEEF);
      check("eq_s_rresp", 64'(e_s_rresp), 64'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("bp_rvalid%0d", i), 64'(e_s_rvalid), 64'd1);
         check($sformatf("bp_rdata%0d", i), 64'(e_s_rdata), 64'hDEADBEEF);
         check($sformatf("bp_m_rready%0d", i), 64'(e_m_rready), 64'd0);
      end
      e_s_rready = 1;
      tick();
      check("eq_s_rvalid_clear", 64'(e_s_rvalid), 64'd0);

      // upsize: back-to-back reads 0x0C then 0x08 of the same 64-bit word
      u_m_arready = 1; u_s_rready = 1;
      u_s_araddr = 32'h0C; u_s_arvalid = 1;
      tick();
      check("up_m_araddr0", 64'(u_m_araddr), 64'h0C);
      check("up_m_arvalid0", 64'(u_m_arvalid), 64'd1);
      u_s_araddr = 32'h08;
      #1;
      check("up_arready_b2b", 64'(u_s_arready), 64'd1);
      tick();
      u_s_arvalid = 0;
      check("up_m_araddr1", 64'(u_m_araddr), 64'h08);
      tick();
      check("up_m_arvalid_idle", 64'(u_m_arvalid), 64'd0);
      u_m_rdata = 64'h11223344_55667788; u_m_rresp = 2'b00; u_m_rvalid = 1;
      tick();
      u_m_rresp = 2'b01;
      check("up_rdata_hi", 64'(u_s_rdata), 64'h11223344);
      check("up_rresp0", 64'(u_s_rresp), 64'd0);
      tick();
      u_m_rvalid = 0;
      check("up_rdata_lo", 64'(u_s_rdata), 64'h55667788);
      check("up_rresp1", 64'(u_s_rresp), 64'd1);
      tick();
      check("up_s_rvalid_clear", 64'(u_s_rvalid), 64'd0);

      // downsize: read 0x24 -> beats at 0x20, 0x24; second beat SLVERR
      d_m_arready = 1;
      d_s_araddr = 32'h24; d_s_arvalid = 1;
      tick();
      d_s_arvalid = 0;
      check("dn_beat0_addr", 64'(d_m_araddr), 64'h20);
      check("dn_beat0_valid", 64'(d_m_arvalid), 64'd1);
      check("dn_arready_issue", 64'(d_s_arready), 64'd0);
      tick();
      check("dn_beat1_addr", 64'(d_m_araddr), 64'h24);
      check("dn_beat1_valid", 64'(d_m_arvalid), 64'd1);
      tick();
      check("dn_ar_done", 64'(d_m_arvalid), 64'd0);
      check("dn_arready_idle", 64'(d_s_arready), 64'd1);
      d_m_rdata = 32'hAAAA0000; d_m_rresp = 2'b00; d_m_rvalid = 1;
      #1;
      check("dn_m_rready_mid", 64'(d_m_rready), 64'd1);
      tick();
      d_m_rdata = 32'hBBBB1111; d_m_rresp = 2'b10;
      check("dn_no_early_rvalid", 64'(d_s_rvalid), 64'd0);
      tick();
      d_m_rvalid = 0;
      check("dn_s_rvalid", 64'(d_s_rvalid), 64'd1);
      check("dn_s_rdata", d_s_rdata, 64'hBBBB1111_AAAA0000);
      check("dn_s_rresp", 64'(d_s_rresp), 64'd2);
      d_s_rready = 1;
      tick();
      check("dn_s_rvalid_clear", 64'(d_s_rvalid), 64'd0);

      // outstanding limit on the equal instance: 6 ARs offered, master silent
      e_m_arready = 1; e_s_rready = 1; acc = 0;
      e_s_arvalid = 1;
      for (int i = 0; i < 6; i++) begin
         e_s_araddr = 32'h100 + 4 * acc;
         #1;
         if (e_s_arready) acc++;
         tick();
      end
      e_s_arvalid = 0;
      check("ot_accepted", 64'(acc), 64'd4);
      check("ot_full_arready", 64'(e_s_arready), 64'd0);
      e_m_rresp = 2'b00; e_m_rvalid = 1;
      for (int k = 0; k < 4; k++) begin
         e_m_rdata = 32'hA0 + k;
         tick();
         check($sformatf("ot_rvalid%0d", k), 64'(e_s_rvalid), 64'd1);
         check($sformatf("ot_rdata%0d", k), 64'(e_s_rdata), 64'(32'hA0 + k));
         check($sformatf("ot_arready%0d", k), 64'(e_s_arready), (k == 0) ? 64'd0 : 64'd1);
      end
      e_m_rvalid = 0;
      tick();
      check("ot_drained", 64'(e_s_rvalid), 64'd0);
      check("ot_arready_end", 64'(e_s_arready), 64'd1);

      // reset during downsize ISSUE with two reads in flight
      d_m_arready = 1; d_s_rready = 1; d_s_arprot = 3'b101;
      d_s_araddr = 32'h40; d_s_arvalid = 1;
      tick();
      d_s_arvalid = 0;
      tick();
      tick();
      d_m_arready = 0;
      d_s_araddr = 32'h48; d_s_arvalid = 1;
      tick();
      d_s_arvalid = 0;
      check("rm_pre_addr", 64'(d_m_araddr), 64'h48);
      check("rm_pre_valid", 64'(d_m_arvalid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rm_m_arvalid", 64'(d_m_arvalid), 64'd0);
      check("rm_m_araddr", 64'(d_m_araddr), 64'd0);
      check("rm_m_arprot", 64'(d_m_arprot), 64'd0);
      check("rm_s_rvalid", 64'(d_s_rvalid), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("rm_post_rvalid", 64'(d_s_rvalid), 64'd0);
      check("rm_post_arready", 64'(d_s_arready), 64'd1);
      check("rm_post_arvalid", 64'(d_m_arvalid), 64'd0);

      // fresh downsize read 0x08 after reset
      d_m_arready = 1; d_s_rready = 0;
      d_s_araddr = 32'h08; d_s_arvalid = 1;
      tick();
      d_s_arvalid = 0;
      check("fr_addr0", 64'(d_m_araddr), 64'h08);
      tick();
      check("fr_addr1", 64'(d_m_araddr), 64'h0C);
      tick();
      check("fr_no_rvalid", 64'(d_s_rvalid), 64'd0);
      d_m_rdata = 32'h33334444; d_m_rresp = 2'b00; d_m_rvalid = 1;
      tick();
      d_m_rdata = 32'h55556666;
      tick();
      d_m_rvalid = 0;
      check("fr_rvalid", 64'(d_s_rvalid), 64'd1);
      check("fr_rdata", d_s_rdata, 64'h55556666_33334444);
      check("fr_rresp", 64'(d_s_rresp), 64'd0);
      d_s_rready = 1;
      tick();
      check("fr_rvalid_clear", 64'(d_s_rvalid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
